stream_arith: RTL and testbench

Two-operand streaming arithmetic unit with an output FIFO, parametrised in data width and buffer depth. It joins two stb/ack input streams and applies one of four operations: wrapping or signed-saturating add/subtract. Each result is queued with an overflow flag and presented on a stb/ack output stream. It replaces the fixed-width adder/subtractor plus external bend chains in toolbox pipelines: one instance supplies both the arithmetic and the elastic buffering.

---
 rtl/stream_arith.sv | 101 ++++++++++
 tb/tb_stream_arith.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arith.sv
// stream_arith: joins two stb/ack operand streams, applies wrapping or
// signed-saturating add/subtract, and queues {ovf, result} in a small FIFO
// presented as a stb/ack output stream.
//
// Overflow is detected by computing one bit wider than the operands: the
// extra bit and the result MSB disagree exactly when the signed result does
// not fit. When clamping, the overflow direction always follows the sign of
// operand A, because both add and subtract can only overflow when A and the
// effective B share a sign.
module stream_arith #(
   parameter int bits  = 16,
   parameter int depth = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [bits-1:0] in1,
   input  logic            in1_stb,
   output logic            in1_ack,
   input  logic [bits-1:0] in2,
   input  logic            in2_stb,
   output logic            in2_ack,
   input  logic [1:0]      op,
   output logic [bits-1:0] out1,
   output logic            out1_ovf,
   output logic            out1_stb,
   input  logic            out1_ack
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] FULL = AW'(depth) == '0 ? (AW+1)'(depth) : (AW+1)'(depth);

   logic [bits:0]   mem_q [depth];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     count_d;

   logic [bits:0]   a_ext;
   logic [bits:0]   b_ext;
   logic [bits:0]   raw;
   logic            ovf;
   logic [bits-1:0] sat_val;
   logic [bits-1:0] res;
   logic            join_ok;
   logic            push;
   logic            pop;

   // Arithmetic for the operation offered this cycle (only stored on a join).
   always_comb begin
      a_ext   = {in1[bits-1], in1};
      b_ext   = {in2[bits-1], in2};
      raw     = op[0] ? (a_ext - b_ext) : (a_ext + b_ext);
      ovf     = raw[bits] ^ raw[bits-1];
      sat_val = in1[bits-1] ? {1'b1, {(bits-1){1'b0}}} : {1'b0, {(bits-1){1'b1}}};
      res     = (op[1] && ovf) ? sat_val : raw[bits-1:0];
   end

   // Join / pop handshakes; a full FIFO blocks the join even if it pops.
   always_comb begin
      join_ok  = rst && in1_stb && in2_stb && (count_q != FULL);
      push     = join_ok;
      pop      = (count_q != '0) && out1_ack;
      in1_ack  = join_ok;
      in2_ack  = join_ok;
      out1_stb = (count_q != '0);
      out1     = mem_q[rd_ptr_q][bits-1:0];
      out1_ovf = mem_q[rd_ptr_q][bits];
   end

   // Occupancy next state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // FIFO storage, pointers and occupancy; reset discards everything queued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {ovf, res};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_stream_arith.sv
module tb_stream_arith;

   localparam int BITS  = 16;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [BITS-1:0] in1 = '0;
   logic            in1_stb = 1'b0;
   logic            in1_ack;
   logic [BITS-1:0] in2 = '0;
   logic            in2_stb = 1'b0;
   logic            in2_ack;
   logic [1:0]      op = 2'b00;
   logic [BITS-1:0] out1;
   logic            out1_ovf;
   logic            out1_stb;
   logic            out1_ack = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic [BITS:0] sb [$];

   stream_arith #(.bits(BITS), .depth(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in1(in1), .in1_stb(in1_stb), .in1_ack(in1_ack),
      .in2(in2), .in2_stb(in2_stb), .in2_ack(in2_ack),
      .op(op),
      .out1(out1), .out1_ovf(out1_ovf), .out1_stb(out1_stb), .out1_ack(out1_ack)
   );

   always #5 clk = ~clk;

   // Reference: exact integer arithmetic, then wrap or clamp to BITS.
   function automatic logic [BITS:0] model(logic [BITS-1:0] a, logic [BITS-1:0] b,
                                           logic [1:0] o);
      int sa, sbv, r, maxv, minv;
      logic v;
      logic [BITS-1:0] q;
      sa   = $signed(a);
      sbv  = $signed(b);
      r    = o[0] ? sa - sbv : sa + sbv;
      maxv = (1 << (BITS-1)) - 1;
      minv = -(1 << (BITS-1));
      v    = (r > maxv) || (r < minv);
      if (o[1] && r > maxv)      q = maxv[BITS-1:0];
      else if (o[1] && r < minv) q = minv[BITS-1:0];
      else                       q = r[BITS-1:0];
      return {v, q};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: predicts handshakes from queue occupancy and checks every pop.
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         check("ack_in_reset", {in1_ack, in2_ack}, 2'b00);
      end else begin
         check("ack_pred", {in1_ack, in2_ack},
               {2{in1_stb && in2_stb && (sb.size() != DEPTH)}});
         check("stb_pred", out1_stb, sb.size() != 0);
         if (out1_stb && out1_ack) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               check("sb_data", {out1_ovf, out1}, sb.pop_front());
            end
         end
         if (in1_stb && in2_stb && in1_ack) sb.push_back(model(in1, in2, op));
      end
   end

   typedef struct {
      logic [BITS-1:0] a;
      logic [BITS-1:0] b;
      logic [1:0]      o;
      logic [BITS-1:0] r;
      logic            v;
   } vec_t;

   vec_t tbl [11];
   int   exp_list [5];
   int   idx;
   bit   joined;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{16'h0003, 16'h0005, 2'b00, 16'h0008, 1'b0};
      tbl[1]  = '{16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b0};
      tbl[2]  = '{16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b1};
      tbl[3]  = '{16'h7FFF, 16'h0001, 2'b10, 16'h7FFF, 1'b1};
      tbl[4]  = '{16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b1};
      tbl[5]  = '{16'h8000, 16'h0001, 2'b11, 16'h8000, 1'b1};
      tbl[6]  = '{16'h8000, 16'h8000, 2'b10, 16'h8000, 1'b1};
      tbl[7]  = '{16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1};
      tbl[8]  = '{16'h7FFF, 16'hFFFF, 2'b11, 16'h7FFF, 1'b1};
      tbl[9]  = '{16'h0000, 16'h8000, 2'b01, 16'h8000, 1'b1};
      tbl[10] = '{16'hFFFF, 16'hFFFF, 2'b10, 16'hFFFE, 1'b0};

      // Reset state, with both operands offered to prove acks are gated.
      in1_stb = 1'b1; in2_stb = 1'b1;
      tick();
      check("rst_stb", out1_stb, 0);
      check("rst_out", out1, 0);
      check("rst_ovf", out1_ovf, 0);
      check("rst_ack", {in1_ack, in2_ack}, 2'b00);
      in1_stb = 1'b0; in2_stb = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Table vectors: each joins into an empty FIFO and shows up one cycle later.
      foreach (tbl[i]) begin
         in1 = tbl[i].a; in2 = tbl[i].b; op = tbl[i].o;
         in1_stb = 1'b1; in2_stb = 1'b1;
         #1;
         check("tbl_join_ack", in1_ack, 1);
         check("tbl_empty_before", out1_stb, 0);
         tick();
         in1_stb = 1'b0; in2_stb = 1'b0;
         op = ~tbl[i].o;
         check("tbl_stb", out1_stb, 1);
         check("tbl_res", out1, tbl[i].r);
         check("tbl_ovf", out1_ovf, tbl[i].v);
         out1_ack = 1'b1;
         tick();
         out1_ack = 1'b0;
         check("tbl_drained", out1_stb, 0);
      end

      // Join stall: lone operand A for five cycles.
      in1 = 16'h0100; in2 = 16'h0023; op = 2'b00;
      in1_stb = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("stall_ack", in1_ack, 0);
         check("stall_stb", out1_stb, 0);
         tick();
      end
      in2_stb = 1'b1;
      #1;
      check("stall_release_ack", {in1_ack, in2_ack}, 2'b11);
      tick();
      in1_stb = 1'b0; in2_stb = 1'b0;
      check("stall_one_stb", out1_stb, 1);
      check("stall_one_res", out1, 16'h0123);
      out1_ack = 1'b1;
      tick();
      out1_ack = 1'b0;
      check("stall_exactly_one", out1_stb, 0);

      // Full / backpressure with a held consumer.
      op = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         in1 = BITS'(k); in2 = BITS'(k);
         in1_stb = 1'b1; in2_stb = 1'b1;
         #1;
         check("full_accept", in1_ack, 1);
         tick();
      end
      in1 = 16'd5; in2 = 16'd5;
      #1;
      check("full_block_ack", {in1_ack, in2_ack}, 2'b00);
      check("full_count", dut.count_q, DEPTH);
      tick();
      check("full_still_block", in1_ack, 0);
      exp_list = '{2, 4, 6, 8, 10};
      idx = 0;
      out1_ack = 1'b1;
      for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
         joined = in1_stb && in1_ack;
         if (out1_stb) begin
            check("full_drain_res", out1, exp_list[idx]);
            check("full_drain_ovf", out1_ovf, 0);
            idx++;
         end
         tick();
         if (joined) begin in1_stb = 1'b0; in2_stb = 1'b0; end
      end
      check("full_drain_count", idx, 5);
      check("full_empty_end", out1_stb, 0);
      out1_ack = 1'b0;
      in1_stb = 1'b0; in2_stb = 1'b0;
      tick();

      // Streaming: continuous joins and acks through several pointer wraps.
      out1_ack = 1'b1;
      in1_stb = 1'b1; in2_stb = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in1 = BITS'(16'h7FF0 + k); in2 = BITS'(k * 3); op = 2'(k);
         #1;
         check("stream_ack", in1_ack, 1);
         check("stream_stb", out1_stb, k != 0);
         check("stream_count", dut.count_q <= 1, 1);
         tick();
      end
      in1_stb = 1'b0; in2_stb = 1'b0;
      tick();
      check("stream_empty", out1_stb, 0);
      out1_ack = 1'b0;

      // Reset mid-operation with three results queued.
      op = 2'b00;
      in1_stb = 1'b1; in2_stb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in1 = BITS'(100 + k); in2 = 16'd1;
         tick();
      end
      in1_stb = 1'b0; in2_stb = 1'b0;
      check("mid_queued", dut.count_q, 3);
      rst = 1'b0;
      #1;
      check("mid_rst_stb", out1_stb, 0);
      check("mid_rst_count", dut.count_q, 0);
      tick();
      rst = 1'b1;
      in1 = 16'h0010; in2 = 16'h0001; op = 2'b00;
      in1_stb = 1'b1; in2_stb = 1'b1;
      tick();
      in1_stb = 1'b0; in2_stb = 1'b0;
      check("mid_first_stb", out1_stb, 1);
      check("mid_first_res", out1, 16'h0011);
      out1_ack = 1'b1;
      tick();
      check("mid_only_one", out1_stb, 0);

      // Randomized traffic against the scoreboard.
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0: in1 = 16'h7FFF;
            1: in1 = 16'h8000;
            default: in1 = BITS'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: in2 = 16'h0001;
            1: in2 = 16'hFFFF;
            default: in2 = BITS'($urandom);
         endcase
         op       = 2'($urandom);
         in1_stb  = ($urandom_range(0, 3) != 0);
         in2_stb  = ($urandom_range(0, 3) != 0);
         out1_ack = ($urandom_range(0, 2) != 0);
         tick();
      end
      in1_stb = 1'b0; in2_stb = 1'b0; out1_ack = 1'b1;
      for (int k = 0; k < 10 && out1_stb; k++) tick();
      check("rand_drained", out1_stb, 0);
      check("rand_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
